// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM stage: datapath widths, pipeline control enums,
// and the access-size / handshake-state enums used by the load/store logic.
package memory_access_stage_pkg;

    localparam int WORD       = 32;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic { MEM_WRITE_DIS = 1'b0, MEM_WRITE_EN = 1'b1 } mem_write_signal;
    typedef enum logic { REG_FILE_WRITE_DIS = 1'b0, REG_FILE_WRITE_EN = 1'b1 } reg_file_write_sig;
    typedef enum logic { SRC_ALU = 1'b0, SRC_MEM = 1'b1 } reg_file_data_source;
    typedef enum logic { NO_BRANCH = 1'b0, BRANCH_FROM_WB = 1'b1 } branch_from_wb;

    typedef enum logic [1:0] { BYTE = 2'd0, HALF = 2'd1, WORD_ACC = 2'd2 } mem_access_size;
    typedef enum logic { IDLE = 1'b0, WAIT_ACK = 1'b1 } mem_fsm_state;

endpackage

// File: rtl/memory_access_stage_mem_access_decoder.sv
// Combinational Thumb load/store decode from instruction bits [15:9]
// into direction, access size and load sign extension.
import memory_access_stage_pkg::*;

module mem_access_decoder (
    input  logic [6:0]     opA_opB,
    output logic           is_load,
    output logic           is_store,
    output mem_access_size size,
    output logic           sign_ext
);
    logic [3:0] op_a;
    logic [2:0] op_b;

    assign op_a = opA_opB[6:3];
    assign op_b = opA_opB[2:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = WORD_ACC;
        sign_ext = 1'b0;
        case (op_a)
            4'b0101: begin
                // Register-offset group: STR/STRH/STRB, then LDRSB, LDR, LDRH, LDRB, LDRSH
                is_store = ~op_b[2] & (op_b[1:0] != 2'b11);
                is_load  = ~is_store;
                sign_ext = (op_b[1:0] == 2'b11);
                case (op_b)
                    3'b000, 3'b100:         size = WORD_ACC;
                    3'b001, 3'b101, 3'b111: size = HALF;
                    default:                size = BYTE;
                endcase
            end
            4'b0110, 4'b1001: begin
                is_load  = op_b[2];
                is_store = ~op_b[2];
                size     = WORD_ACC;
            end
            4'b0111: begin
                is_load  = op_b[2];
                is_store = ~op_b[2];
                size     = BYTE;
            end
            4'b1000: begin
                is_load  = op_b[2];
                is_store = ~op_b[2];
                size     = HALF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/ack data port,
// front-end stall while waiting, MEM/WB register. Optional macro: ALIGN_CHECK_EN.
import memory_access_stage_pkg::*;

module memory_access_stage (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   is_valid_i,
    input  mem_write_signal        mem_write_en_i,
    input  reg_file_write_sig      reg_file_write_en_i,
    input  reg_file_data_source    reg_file_data_source_i,
    input  branch_from_wb          branch_from_wb_i,
    input  logic [6:0]             opA_opB_i,
    input  logic [ADDR_WIDTH-1:0]  reg_dest_addr_i,
    input  logic [WORD-1:0]        alu_result_i,
    input  logic [WORD-1:0]        reg_2_data_i,
    input  logic [WORD-1:0]        dmem_rdata_i,
    input  logic                   dmem_ack_i,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [WORD-1:0]        dmem_addr_o,
    output logic [3:0]             dmem_be_o,
    output logic [WORD-1:0]        dmem_wdata_o,
    output logic                   stall_o,
    output logic [ADDR_WIDTH-1:0]  fwd_reg_dest_o,
    output logic [WORD-1:0]        fwd_reg_data_o,
    output reg_file_write_sig      fwd_reg_write_en_o,
    output logic                   is_valid_o,
    output reg_file_write_sig      reg_file_write_en_o,
    output reg_file_data_source    reg_file_data_source_o,
    output branch_from_wb          branch_from_wb_o,
    output logic [ADDR_WIDTH-1:0]  reg_dest_addr_o,
    output logic [WORD-1:0]        reg_data_o
`ifdef ALIGN_CHECK_EN
    ,
    output logic                   align_fault_o
`endif
);
    logic           dec_load, dec_store, dec_sign;
    mem_access_size dec_size;
    mem_fsm_state   state;
    logic [1:0]     lane;
    logic           mem_op, misaligned, fault, req;

    // Direction is taken from the decoded opcode; the EXE-side store enable is redundant.
    logic unused_mem_write_en;
    assign unused_mem_write_en = mem_write_en_i;

    mem_access_decoder u_dec (
        .opA_opB  (opA_opB_i),
        .is_load  (dec_load),
        .is_store (dec_store),
        .size     (dec_size),
        .sign_ext (dec_sign)
    );

    function automatic logic [WORD-1:0] load_extend(input logic [WORD-1:0] rdata,
                                                    input logic [1:0] sel,
                                                    input mem_access_size sz,
                                                    input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{sel, 3'b000} +: 8];
        h = sel[1] ? rdata[31:16] : rdata[15:0];
        case (sz)
            BYTE:    return sx ? {{24{b[7]}}, b} : {24'd0, b};
            HALF:    return sx ? {{16{h[15]}}, h} : {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sel, input mem_access_size sz);
        case (sz)
            BYTE:    return 4'b0001 << sel;
            HALF:    return sel[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [WORD-1:0] store_lanes(input logic [WORD-1:0] d, input mem_access_size sz);
        case (sz)
            BYTE:    return {4{d[7:0]}};
            HALF:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign lane   = alu_result_i[1:0];
    assign mem_op = is_valid_i & (dec_load | dec_store);

`ifdef ALIGN_CHECK_EN
    always_comb begin
        case (dec_size)
            HALF:     misaligned = lane[0];
            WORD_ACC: misaligned = |lane;
            default:  misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign fault = mem_op & misaligned;
    // Upstream holds its inputs while stalled, so WAIT_ACK keeps the request alive.
    assign req   = reset_i & ((state == WAIT_ACK) | (mem_op & ~fault));

    assign dmem_req_o   = req;
    assign dmem_we_o    = dec_store;
    assign dmem_addr_o  = {alu_result_i[WORD-1:2], 2'b00};
    assign dmem_be_o    = store_be(lane, dec_size);
    assign dmem_wdata_o = store_lanes(reg_2_data_i, dec_size);
    assign stall_o      = req & ~dmem_ack_i;

    assign fwd_reg_dest_o = reg_dest_addr_i;
    assign fwd_reg_data_o = alu_result_i;
    always_comb begin
        fwd_reg_write_en_o = REG_FILE_WRITE_DIS;
        if (is_valid_i && !dec_load)
            fwd_reg_write_en_o = reg_file_write_en_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (req && !dmem_ack_i) state <= WAIT_ACK;
                WAIT_ACK: if (dmem_ack_i) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // MEM/WB register boundary
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            is_valid_o             <= 1'b0;
            reg_file_write_en_o    <= REG_FILE_WRITE_DIS;
            reg_file_data_source_o <= SRC_ALU;
            branch_from_wb_o       <= NO_BRANCH;
            reg_dest_addr_o        <= '0;
            reg_data_o             <= '0;
        end else if (stall_o || fault) begin
            is_valid_o          <= 1'b0;
            reg_file_write_en_o <= REG_FILE_WRITE_DIS;
            branch_from_wb_o    <= NO_BRANCH;
        end else begin
            is_valid_o             <= is_valid_i;
            reg_file_write_en_o    <= is_valid_i ? reg_file_write_en_i : REG_FILE_WRITE_DIS;
            reg_file_data_source_o <= reg_file_data_source_i;
            branch_from_wb_o       <= branch_from_wb_i;
            reg_dest_addr_o        <= reg_dest_addr_i;
            reg_data_o             <= (mem_op && dec_load) ?
                                      load_extend(dmem_rdata_i, lane, dec_size, dec_sign) : alu_result_i;
        end
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) align_fault_o <= 1'b0;
        else          align_fault_o <= fault;
    end
`endif

endmodule
